data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Purpose: arbitrates a CPU port and a video-fetch read port onto one synchronous data RAM.
// Latency: fixed; a request sampled in IDLE on edge N is acknowledged (ack + rdata) in cycle N+2.
// Backpressure: loser's request stays pending; requests are only sampled while IDLE.
//
// Ports:
//   sys_clock, reset           - clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      - CPU request side; cpu_rdata/cpu_ack response
//   vid_req/vid_addr           - video read request; vid_rdata/vid_ack response
//   vblank                     - blanking interval, flips contention priority to the CPU
//   mem_addr/we/wdata/rdata    - RAM side (RAM read data arrives one cycle after address)
//   busy                       - FSM not in IDLE
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    input  logic              vblank,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [2:0] STARVE_MAX = 3'd4;

    logic [1:0]        state_q, state_d;
    logic              win_cpu_q, win_cpu_d;
    logic [2:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              vid_ack_q, vid_ack_d;

    logic any_req;
    logic cpu_wins;

    assign any_req = cpu_req | vid_req;

    // CPU takes the slot if it is alone, during blanking, or once it has
    // lost enough contested rounds; otherwise active video has priority.
    assign cpu_wins = cpu_req & (~vid_req | vblank | (starve_q == STARVE_MAX));

    // State register
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath: grant capture, RAM command, response registers
    always_comb begin
        win_cpu_d   = win_cpu_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    win_cpu_d = cpu_wins;
                    if (cpu_wins) begin
                        mem_addr_d  = cpu_addr;
                        mem_we_d    = cpu_we;
                        mem_wdata_d = cpu_wdata;
                        starve_d    = 3'd0;
                    end else begin
                        mem_addr_d  = vid_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        // Only a CPU that was actually asking counts as starved.
                        if (cpu_req && (starve_q != STARVE_MAX)) begin
                            starve_d = starve_q + 3'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                // RAM data for the address issued in ACCESS is valid now.
                if (win_cpu_q) begin
                    cpu_rdata_d = mem_rdata;
                    cpu_ack_d   = 1'b1;
                end else begin
                    vid_rdata_d = mem_rdata;
                    vid_ack_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            win_cpu_q   <= 1'b0;
            starve_q    <= 3'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            vid_rdata_q <= '0;
            vid_ack_q   <= 1'b0;
        end else begin
            win_cpu_q   <= win_cpu_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_rdata_q <= vid_rdata_d;
            vid_ack_q   <= vid_ack_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_rdata = vid_rdata_q;
    assign vid_ack   = vid_ack_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Purpose: directed, table-driven bench for data_mem_arbiter with a behavioural sync RAM.
// Latency: latencies are counted in rising edges after the request is driven (single winner = 3).
// Backpressure: requesters drop req as soon as they observe their ack.
module tb_data_mem_arbiter;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_ack;
    logic       vid_req;
    logic [7:0] vid_addr, vid_rdata;
    logic       vid_ack;
    logic       vblank;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 sys_clock = ~sys_clock;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_rdata (vid_rdata),
        .vid_ack   (vid_ack),
        .vblank    (vblank),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Synchronous RAM: read data for the presented address appears one edge later.
    logic [7:0] ram [256];
    always @(posedge sys_clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       c_req;
        logic       c_we;
        logic [7:0] c_addr;
        logic [7:0] c_wdata;
        logic       v_req;
        logic [7:0] v_addr;
        logic       vbl;
        int         e_clat;
        int         e_vlat;
        logic [7:0] e_crd;
        logic [7:0] e_vrd;
    } vec_t;

    vec_t vecs [9];

    // One CPU access; optional corruption of address/data right after the grant edge.
    task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic corrupt, output logic [7:0] rd, output int lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        lat = 0; rd = 8'h00;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge sys_clock); #1;
            if (corrupt && cyc == 1) begin
                cpu_addr = 8'h50; cpu_wdata = 8'h11;
            end
            if (cpu_ack) begin
                lat = cyc; rd = cpu_rdata; cpu_req = 1'b0;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        logic [7:0] rd, crd, vrd;
        int         lat, clat, vlat, wecnt, vid_acks, cpu_lat;
        logic       both;

        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hC3;
        ram[8'h20] = 8'h3C;

        //            c_req c_we addr   wdata  v_req vaddr  vbl clat vlat crd    vrd
        vecs[0] = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0, 3, 0, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0, 3, 0, 8'hA5, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b0, 0, 3, 8'h00, 8'h3C};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b1, 0, 3, 8'h00, 8'h3C};
        vecs[4] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'h20, 1'b0, 6, 3, 8'hA5, 8'h3C};
        vecs[5] = '{1'b1, 1'b1, 8'h30, 8'h77, 1'b1, 8'h21, 1'b1, 3, 6, 8'h00, 8'hE2};
        vecs[6] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 8'h00, 1'b0, 3, 0, 8'h77, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 1'b1, 0, 3, 8'h00, 8'h77};
        vecs[8] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h10, 1'b1, 3, 6, 8'h3C, 8'hA5};

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        vid_req = 1'b0; vid_addr = 8'h00; vblank = 1'b0;
        repeat (2) @(posedge sys_clock);
        #1;
        chk("rst_cpu_ack",   cpu_ack,   1'b0);
        chk("rst_vid_ack",   vid_ack,   1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_vid_rdata", vid_rdata, 8'h00);
        chk("rst_mem_addr",  mem_addr,  8'h00);
        chk("rst_mem_we",    mem_we,    1'b0);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_busy",      busy,      1'b0);
        reset = 1'b0;
        @(posedge sys_clock); #1;

        // Table-driven single and contested accesses
        for (int i = 0; i < 9; i++) begin
            cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
            cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
            vid_req = vecs[i].v_req; vid_addr = vecs[i].v_addr; vblank = vecs[i].vbl;
            clat = 0; vlat = 0; wecnt = 0; both = 1'b0; crd = 8'h00; vrd = 8'h00;
            for (int cyc = 1; cyc <= 20; cyc++) begin
                @(posedge sys_clock); #1;
                if (mem_we) wecnt++;
                if (cpu_ack && vid_ack) both = 1'b1;
                if (cpu_ack && clat == 0) begin clat = cyc; crd = cpu_rdata; cpu_req = 1'b0; end
                if (vid_ack && vlat == 0) begin vlat = cyc; vrd = vid_rdata; vid_req = 1'b0; end
                if ((clat != 0 || !vecs[i].c_req) && (vlat != 0 || !vecs[i].v_req)) break;
            end
            cpu_req = 1'b0; vid_req = 1'b0;
            chk($sformatf("v%0d_cpu_lat", i), clat, vecs[i].e_clat);
            chk($sformatf("v%0d_vid_lat", i), vlat, vecs[i].e_vlat);
            chk($sformatf("v%0d_we_cnt", i), wecnt, (vecs[i].c_req && vecs[i].c_we) ? 1 : 0);
            chk($sformatf("v%0d_both_ack", i), both, 1'b0);
            if (vecs[i].c_req && !vecs[i].c_we) chk($sformatf("v%0d_cpu_rdata", i), crd, vecs[i].e_crd);
            if (vecs[i].v_req) chk($sformatf("v%0d_vid_rdata", i), vrd, vecs[i].e_vrd);
            if (i == 2) begin
                @(posedge sys_clock); #1;
                chk("idle_mem_we",        mem_we,    1'b0);
                chk("idle_mem_addr_hold", mem_addr,  8'h20);
                chk("vid_mem_wdata_zero", mem_wdata, 8'h00);
            end
        end

        // Starvation: video held continuously, CPU must win the fifth grant
        @(posedge sys_clock); #1;
        vblank = 1'b0; vid_req = 1'b1; vid_addr = 8'h20;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        vid_acks = 0; cpu_lat = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge sys_clock); #1;
            if (vid_ack) vid_acks++;
            if (cpu_ack) begin cpu_lat = cyc; cpu_req = 1'b0; break; end
        end
        chk("starve_vid_grants", vid_acks, 4);
        chk("starve_cpu_lat", cpu_lat, 15);
        chk("starve_cnt_cleared", dut.starve_q, 3'd0);
        lat = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge sys_clock); #1;
            if (vid_ack) begin lat = cyc; vid_req = 1'b0; break; end
        end
        vid_req = 1'b0;
        chk("starve_vid_after", lat, 3);

        // Reset during ACCESS of a CPU write, then reissue
        @(posedge sys_clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h99;
        @(posedge sys_clock); #1;
        chk("abort_we_in_access", mem_we, 1'b1);
        chk("abort_busy_in_access", busy, 1'b1);
        reset = 1'b1;
        @(posedge sys_clock); #1;
        chk("abort_mem_we", mem_we, 1'b0);
        chk("abort_cpu_ack", cpu_ack, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_cpu_rdata", cpu_rdata, 8'h00);
        reset = 1'b0;
        lat = 0; wecnt = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge sys_clock); #1;
            if (mem_we) wecnt++;
            if (cpu_ack) begin lat = cyc; cpu_req = 1'b0; break; end
        end
        cpu_req = 1'b0;
        chk("reissue_lat", lat, 3);
        chk("reissue_we_cnt", wecnt, 1);
        cpu_access(1'b0, 8'h40, 8'h00, 1'b0, rd, lat);
        chk("reissue_readback", rd, 8'h99);

        // Address/data changes after grant must not disturb the access
        cpu_access(1'b1, 8'h31, 8'h42, 1'b1, rd, lat);
        chk("hold_write_lat", lat, 3);
        cpu_access(1'b0, 8'h31, 8'h00, 1'b0, rd, lat);
        chk("hold_write_target", rd, 8'h42);
        cpu_access(1'b0, 8'h50, 8'h00, 1'b0, rd, lat);
        chk("hold_other_addr", rd, 8'h93);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
